// File: rtl/idli_pkg.sv
// Shared SQI definitions: command opcodes, responder FSM states and the bus direction type.
package idli_pkg;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  // Direction as seen by the initiator: IN = initiator reads, OUT = initiator drives.
  typedef enum logic {
    SQI_MODE_IN  = 1'b0,
    SQI_MODE_OUT = 1'b1
  } sqi_mode_t;

  typedef enum logic [2:0] {
    SQI_RESP_IDLE,
    SQI_RESP_INSTR,
    SQI_RESP_ADDR,
    SQI_RESP_DUMMY,
    SQI_RESP_RDATA,
    SQI_RESP_WDATA,
    SQI_RESP_IGNORE
  } sqi_resp_state_t;

endpackage

// File: rtl/idli_sqi_mem_m.sv
// Responder backing store: byte array with a registered write port and an asynchronous read port.
module idli_sqi_mem_m #(
  parameter int MEM_AW = 8
) (
  input  logic              i_core_gck,
  input  logic              i_we,
  input  logic [MEM_AW-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [MEM_AW-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [2**MEM_AW];

  always_ff @(posedge i_core_gck) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/idli_sqi_resp_m.sv
// SQI serial-SRAM responder: samples initiator nibbles on SCK rise, drives read data on SCK fall,
// and serves READ (0x03) / WRITE (0x02) transactions from an internal byte array.
module idli_sqi_resp_m
  import idli_pkg::*;
#(
  parameter int MEM_AW        = 8,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic      i_core_gck,
  input  logic      i_core_rst_n,
  input  logic      i_resp_sqi_sck,
  input  logic      i_resp_sqi_cs,
  input  sqi_mode_t i_resp_sqi_mode,
  input  logic [3:0] i_resp_sqi_data,
  output logic [3:0] o_resp_sqi_data,
  output logic      o_resp_sqi_oe,
  output logic      o_resp_err
);

  sqi_resp_state_t r_state, w_state_nxt;
  logic        r_sck_q;
  logic [7:0]  r_cnt;
  logic [3:0]  r_instr_hi;
  logic [3:0]  r_wr_hi;
  logic        r_is_wr;
  logic [23:0] r_addr;
  logic        w_rise, w_fall, w_we;
  logic [7:0]  w_rdata;
  logic [7:0]  w_instr;

  // SCK is generated in this clock domain, so plain edge detection suffices.
  assign w_rise  = i_resp_sqi_sck & ~r_sck_q;
  assign w_fall  = ~i_resp_sqi_sck & r_sck_q;
  assign w_instr = {r_instr_hi, i_resp_sqi_data};
  assign w_we    = ~i_resp_sqi_cs && (r_state == SQI_RESP_WDATA) && w_rise && r_cnt[0];

  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) r_state <= SQI_RESP_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_resp_sqi_cs) begin
      w_state_nxt = SQI_RESP_IDLE;
    end else begin
      case (r_state)
        SQI_RESP_IDLE:  w_state_nxt = SQI_RESP_INSTR;
        SQI_RESP_INSTR: if (w_rise && r_cnt == 8'd1)
          w_state_nxt = (w_instr == SQI_CMD_READ || w_instr == SQI_CMD_WRITE) ? SQI_RESP_ADDR
                                                                              : SQI_RESP_IGNORE;
        SQI_RESP_ADDR:  if (w_rise && r_cnt == 8'd5)
          w_state_nxt = r_is_wr ? SQI_RESP_WDATA
                      : (DUMMY_NIBBLES == 0) ? SQI_RESP_RDATA : SQI_RESP_DUMMY;
        SQI_RESP_DUMMY: if (w_rise && r_cnt == 8'(DUMMY_NIBBLES - 1))
          w_state_nxt = SQI_RESP_RDATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      r_sck_q         <= 1'b0;
      r_cnt           <= '0;
      r_instr_hi      <= '0;
      r_wr_hi         <= '0;
      r_is_wr         <= 1'b0;
      r_addr          <= '0;
      o_resp_sqi_data <= '0;
      o_resp_sqi_oe   <= 1'b0;
      o_resp_err      <= 1'b0;
    end else begin
      r_sck_q <= i_resp_sqi_sck;
      if (o_resp_sqi_oe && i_resp_sqi_mode == SQI_MODE_OUT) o_resp_err <= 1'b1;
      if (i_resp_sqi_cs) begin
        r_cnt           <= '0;
        o_resp_sqi_oe   <= 1'b0;
        o_resp_sqi_data <= '0;
      end else begin
        case (r_state)
          SQI_RESP_IDLE: r_cnt <= '0;
          SQI_RESP_INSTR: if (w_rise) begin
            r_instr_hi <= i_resp_sqi_data;
            if (r_cnt == 8'd1) begin
              r_cnt   <= '0;
              r_is_wr <= (w_instr == SQI_CMD_WRITE);
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          SQI_RESP_ADDR: if (w_rise) begin
            r_addr <= {r_addr[19:0], i_resp_sqi_data};
            r_cnt  <= (r_cnt == 8'd5) ? 8'd0 : r_cnt + 8'd1;
          end
          SQI_RESP_DUMMY: if (w_rise)
            r_cnt <= (r_cnt == 8'(DUMMY_NIBBLES - 1)) ? 8'd0 : r_cnt + 8'd1;
          // r_cnt[0] tracks which half of the byte goes out next.
          SQI_RESP_RDATA: if (w_fall) begin
            o_resp_sqi_oe <= 1'b1;
            if (!r_cnt[0]) begin
              o_resp_sqi_data <= w_rdata[7:4];
              r_cnt           <= 8'd1;
            end else begin
              o_resp_sqi_data <= w_rdata[3:0];
              r_addr          <= r_addr + 24'd1;
              r_cnt           <= 8'd0;
            end
          end
          SQI_RESP_WDATA: if (w_rise) begin
            if (!r_cnt[0]) begin
              r_wr_hi <= i_resp_sqi_data;
              r_cnt   <= 8'd1;
            end else begin
              r_addr <= r_addr + 24'd1;
              r_cnt  <= 8'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  idli_sqi_mem_m #(.MEM_AW(MEM_AW)) u_mem (
    .i_core_gck (i_core_gck),
    .i_we       (w_we),
    .i_waddr    (r_addr[MEM_AW-1:0]),
    .i_wdata    ({r_wr_hi, i_resp_sqi_data}),
    .i_raddr    (r_addr[MEM_AW-1:0]),
    .o_rdata    (w_rdata)
  );

endmodule
